// File: rtl/ps2_arrow_key_receiver.sv
// rtl/ps2_arrow_key_receiver.sv - PS/2 set-2 frame receiver with arrow-key make decoder
// Receives 11-bit keyboard frames and turns E0-prefixed arrow makes into one-cycle strobes.
module ps2_arrow_key_receiver #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       Key_left,
  output logic       Key_right,
  output logic       Key_up,
  output logic       Key_down,
  output logic [7:0] Scan_code,
  output logic       Scan_valid,
  output logic       Frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP,
    RX_DONE
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_strobe;

  rx_state_t r_rx_state;
  rx_state_t w_rx_next;
  logic [TW-1:0] r_timeout;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity_ok;
  logic          r_stop_ok;
  logic [7:0]    r_scan_code;
  logic          r_scan_valid;
  logic          r_frame_err;
  logic          w_begin;
  logic          w_start_err;
  logic          w_timeout;
  logic          w_done_ok;
  logic          w_done_bad;

  dec_state_t r_dec_state;
  dec_state_t w_dec_next;
  logic [3:0] r_held;
  logic [3:0] w_arrow_oh;
  logic [3:0] w_key;
  logic [3:0] w_clr;

  // Sync chains reset to the idle-high line level so reset never fakes a falling edge.
  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_strobe = r_clk_prev & ~w_clk_s;

  always_comb begin
    w_rx_next   = r_rx_state;
    w_begin     = 1'b0;
    w_start_err = 1'b0;
    w_timeout   = 1'b0;
    case (r_rx_state)
      RX_IDLE, RX_DONE: begin
        if (r_rx_state == RX_DONE) w_rx_next = RX_IDLE;
        if (w_strobe) begin
          if (!w_data_s) begin
            w_rx_next = RX_SHIFT;
            w_begin   = 1'b1;
          end else begin
            w_start_err = 1'b1;
          end
        end
      end
      RX_SHIFT:  if (w_strobe && r_bit_cnt == 3'd7) w_rx_next = RX_PARITY;
      RX_PARITY: if (w_strobe) w_rx_next = RX_STOP;
      RX_STOP:   if (w_strobe) w_rx_next = RX_DONE;
      default:   w_rx_next = RX_IDLE;
    endcase
    if (r_rx_state != RX_IDLE && !w_strobe && r_timeout == TO_LAST) begin
      w_timeout = 1'b1;
      w_rx_next = RX_IDLE;
    end
  end

  assign w_done_ok  = (r_rx_state == RX_DONE) && r_parity_ok && r_stop_ok;
  assign w_done_bad = (r_rx_state == RX_DONE) && !(r_parity_ok && r_stop_ok);

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      r_rx_state   <= RX_IDLE;
      r_timeout    <= '0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_parity_ok  <= 1'b0;
      r_stop_ok    <= 1'b0;
      r_scan_code  <= 8'd0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_strobe || w_rx_next == RX_IDLE) r_timeout <= '0;
      else r_timeout <= r_timeout + TW'(1);
      if (w_begin || w_timeout) begin
        r_bit_cnt <= 3'd0;
      end else if (r_rx_state == RX_SHIFT && w_strobe) begin
        r_shift   <= {w_data_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (r_rx_state == RX_PARITY && w_strobe) r_parity_ok <= ^{w_data_s, r_shift};
      if (r_rx_state == RX_STOP && w_strobe) r_stop_ok <= w_data_s;
      r_scan_valid <= w_done_ok;
      if (w_done_ok) r_scan_code <= r_shift;
      r_frame_err <= w_done_bad | w_start_err | w_timeout;
    end
  end

  always_comb begin
    case (r_scan_code)
      8'h6B:   w_arrow_oh = 4'b0001;
      8'h74:   w_arrow_oh = 4'b0010;
      8'h75:   w_arrow_oh = 4'b0100;
      8'h72:   w_arrow_oh = 4'b1000;
      default: w_arrow_oh = 4'b0000;
    endcase
  end

  // Key strobes come straight from the decoder so they line up with the final Scan_valid.
  always_comb begin
    w_dec_next = r_dec_state;
    w_key      = 4'b0000;
    w_clr      = 4'b0000;
    if (r_frame_err) begin
      w_dec_next = DEC_IDLE;
    end else if (r_scan_valid) begin
      case (r_dec_state)
        DEC_IDLE: begin
          if (r_scan_code == 8'hE0) w_dec_next = DEC_EXT;
          else if (r_scan_code == 8'hF0) w_dec_next = DEC_BRK;
        end
        DEC_EXT: begin
          if (r_scan_code == 8'hF0) begin
            w_dec_next = DEC_EXT_BRK;
          end else begin
            w_dec_next = DEC_IDLE;
            w_key      = w_arrow_oh & ~r_held;
          end
        end
        DEC_BRK: w_dec_next = DEC_IDLE;
        DEC_EXT_BRK: begin
          w_dec_next = DEC_IDLE;
          w_clr      = w_arrow_oh;
        end
        default: w_dec_next = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      r_dec_state <= DEC_IDLE;
      r_held      <= 4'b0000;
    end else begin
      r_dec_state <= w_dec_next;
      r_held      <= (r_held | w_key) & ~w_clr;
    end
  end

  assign Key_left   = w_key[0];
  assign Key_right  = w_key[1];
  assign Key_up     = w_key[2];
  assign Key_down   = w_key[3];
  assign Scan_code  = r_scan_code;
  assign Scan_valid = r_scan_valid;
  assign Frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_arrow_key_receiver.sv
// tb/tb_ps2_arrow_key_receiver.sv - scoreboard bench for ps2_arrow_key_receiver
// Byte-sequence reference model feeds an expectation queue consumed by a monitor.
module tb_ps2_arrow_key_receiver;
  localparam int T  = 300;
  localparam int S  = 2;
  localparam int HP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  logic kl, kr, ku, kd, sv, fe;
  logic [7:0] sc;

  always #10 clk = ~clk;

  ps2_arrow_key_receiver #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .Clk_50mhz(clk), .Rst(rst), .PS2_clk(ps2c), .PS2_data(ps2d),
    .Key_left(kl), .Key_right(kr), .Key_up(ku), .Key_down(kd),
    .Scan_code(sc), .Scan_valid(sv), .Frame_err(fe)
  );

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [3:0] keys;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  logic [7:0] seq[$];
  bit   held[4];
  logic [7:0] last_code = 8'h00;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h6B:   return 0;
      8'h74:   return 1;
      8'h75:   return 2;
      8'h72:   return 3;
      default: return -1;
    endcase
  endfunction

  // A sequence is complete once the bytes so far are no longer a known prefix.
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    int   idx;
    e.err = 1'b0; e.code = b; e.keys = 4'b0000;
    seq.push_back(b);
    last_code = b;
    if (seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) begin
    end else if (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0) begin
    end else begin
      idx = arrow_idx(b);
      if (idx >= 0 && seq.size() == 2 && seq[0] == 8'hE0) begin
        if (!held[idx]) begin
          e.keys[idx] = 1'b1;
          held[idx]   = 1'b1;
        end
      end else if (idx >= 0 && seq.size() == 3 && seq[0] == 8'hE0 && seq[1] == 8'hF0) begin
        held[idx] = 1'b0;
      end
      seq.delete();
    end
    expq.push_back(e);
  endtask

  task automatic model_err();
    exp_t e;
    seq.delete();
    e.err = 1'b1; e.code = last_code; e.keys = 4'b0000;
    expq.push_back(e);
  endtask

  task automatic ps2_bit(input logic b, input bit measure);
    int n;
    @(negedge clk);
    ps2d = b;
    repeat (HP) @(negedge clk);
    ps2c = 1'b0;
    if (measure) begin
      n = 0;
      while (n < 20 && !(sv || fe)) begin
        @(posedge clk); #1;
        n++;
      end
      check("stop_latency", 32'(n), 32'(S + 2));
    end
    repeat (HP) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
      end
      ps2_bit(f[i], i == 10);
    end
    ps2d = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sv || fe) begin
        if (expq.size() == 0) begin
          check("unexpected_output", {30'd0, sv, fe}, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          check("frame_err", 32'(fe), 32'(mon_e.err));
          check("scan_valid", 32'(sv), 32'(!mon_e.err));
          check("scan_code", 32'(sc), 32'(mon_e.code));
          check("keys", 32'({kd, ku, kr, kl}), 32'(mon_e.keys));
        end
      end else if (kl || kr || ku || kd) begin
        check("key_without_valid", 32'({kd, ku, kr, kl}), 32'd0);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] arr[4];
    logic [7:0] rb;
    int n;
    bit got;
    arr[0] = 8'h6B; arr[1] = 8'h74; arr[2] = 8'h75; arr[3] = 8'h72;
    for (int i = 0; i < 4; i++) held[i] = 1'b0;

    repeat (5) @(negedge clk);
    check("reset_outputs", 32'({kl, kr, ku, kd, sv, fe, sc}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    for (int i = 0; i < 2; i++) begin
      send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    end
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);

    send_frame(8'h6B, 1, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);

    // Truncated frame: start plus four data bits of 0x72, then the line idles.
    model_err();
    ps2_bit(1'b0, 0); ps2_bit(1'b0, 0); ps2_bit(1'b1, 0); ps2_bit(1'b0, 0);
    @(negedge clk);
    ps2d = 1'b0;
    repeat (HP) @(negedge clk);
    ps2c = 1'b0;
    n = 0; got = 1'b0;
    while (n < T + 60 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == HP) ps2c = 1'b1;
      if (fe) got = 1'b1;
    end
    ps2c = 1'b1; ps2d = 1'b1;
    check("timeout_latency", 32'(n), 32'(T + S + 1));
    repeat (HP) @(negedge clk);
    send_frame(8'hE0, 0, 0); send_frame(8'h72, 0, 0);

    // Partial 0x74 frame abandoned by reset.
    send_frame(8'hE0, 0, 0);
    ps2_bit(1'b0, 0); ps2_bit(1'b0, 0); ps2_bit(1'b0, 0); ps2_bit(1'b1, 0);
    ps2d = 1'b1;
    repeat (HP) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("outputs_in_reset", 32'({kl, kr, ku, kd, sv, fe, sc}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seq.delete();
    for (int i = 0; i < 4; i++) held[i] = 1'b0;
    last_code = 8'h00;
    check("outputs_after_reset", 32'({kl, kr, ku, kd, sv, fe, sc}), 32'd0);
    send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);

    send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0); send_frame(8'h6B, 0, 0);

    model_err();
    ps2_bit(1'b1, 0);
    repeat (HP) @(negedge clk);
    send_frame(8'hAA, 0, 0); send_frame(8'hFA, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h74, 0, 0);
    send_frame(8'hEE, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
    send_frame(8'h72, 0, 1);

    for (int it = 0; it < 40; it++) begin
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: begin send_frame(8'hE0, 0, 0); send_frame(arr[$urandom_range(0, 3)], 0, 0); end
        1: begin
          send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0);
          send_frame(arr[$urandom_range(0, 3)], 0, 0);
        end
        2: send_frame(rb, 0, 0);
        3: begin send_frame(8'hF0, 0, 0); send_frame(rb, 0, 0); end
        4: if ($urandom_range(0, 1) == 0) send_frame(rb, 1, 0);
           else send_frame(rb, 0, 1);
        default: begin send_frame(8'hE0, 0, 0); send_frame(rb, 0, 0); end
      endcase
    end

    repeat (50) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
